// File: rtl/sa2_squarer.sv
// sa2_squarer: free-running shift-and-add squarer with a saturating registered result
module sa2_squarer #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         reset,
  input  logic         clk,
  output logic [W-1:0] q
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {LOAD, ITER, DONE} state_t;
  state_t state, nxt;
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0] mplier;
  logic [CW-1:0] cnt;
  logic load, iter, done;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= LOAD;
    else state <= nxt;
  always_comb
    nxt = state == LOAD ? ITER : state == ITER ? (cnt == LAST ? DONE : ITER) : LOAD;
  always_comb begin
    load = state == LOAD;
    iter = state == ITER;
    done = state == DONE;
  end
  // any bit above the low W of the square means it no longer fits in q
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q      <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{W{1'b0}}, a};
      mplier <= a;
      acc    <= '0;
      cnt    <= '0;
    end else if (iter) begin
      acc    <= mplier[0] ? acc + mcand : acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end else if (done) begin
      q <= |acc[2*W-1:W] ? '1 : acc[W-1:0];
    end
endmodule

// File: tb/tb_sa2_squarer.sv
// tb_sa2_squarer: directed table-driven check of the saturating sequential squarer
module tb_sa2_squarer;
  logic [7:0] a;
  logic reset;
  logic clk;
  logic [7:0] q;
  int checks = 0;
  int fails = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[11];
  logic [7:0] prev;

  sa2_squarer #(.W(8)) dut (.a(a), .reset(reset), .clk(clk), .q(q));

  initial clk = 1'b0;
  always #60 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: q=%0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one full period: a is sampled on the next edge, q must hold until the 10th edge
  task automatic period(input string name, input logic [7:0] av, input logic [7:0] exp);
    a = av;
    repeat (9) @(posedge clk);
    #1 check({name, "_hold"}, q, prev);
    @(posedge clk);
    #1 check(name, q, exp);
    prev = exp;
  endtask

  initial begin
    vecs[0]  = '{8'd0,   8'd0};
    vecs[1]  = '{8'd1,   8'd1};
    vecs[2]  = '{8'd12,  8'd144};
    vecs[3]  = '{8'd15,  8'd225};
    vecs[4]  = '{8'd16,  8'd255};
    vecs[5]  = '{8'd255, 8'd255};
    vecs[6]  = '{8'd3,   8'd9};
    vecs[7]  = '{8'd10,  8'd100};
    vecs[8]  = '{8'd128, 8'd255};
    vecs[9]  = '{8'd7,   8'd49};
    vecs[10] = '{8'd170, 8'd255};
    a = 8'd0;
    reset = 1'b0;
    #10 reset = 1'b1;
    #40 check("reset_async", q, 8'd0);
    #40 reset = 1'b0;
    a = 8'd12;
    prev = 8'd0;
    period("basic_12", 8'd12, 8'd144);
    period("basic_12_again", 8'd12, 8'd144);
    for (int i = 0; i < 11; i++) period($sformatf("vec%0d_a%0d", i, vecs[i].a), vecs[i].a, vecs[i].exp);
    a = 8'd12;
    repeat (3) @(posedge clk);
    #1 a = 8'd3;
    repeat (7) @(posedge clk);
    #1 check("midchange_old", q, 8'd144);
    prev = 8'd144;
    period("midchange_new", 8'd3, 8'd9);
    a = 8'd200;
    repeat (4) @(posedge clk);
    #20 reset = 1'b1;
    #1 check("reset_mid_iter", q, 8'd0);
    @(negedge clk);
    check("reset_held", q, 8'd0);
    reset = 1'b0;
    prev = 8'd0;
    period("after_reset_5", 8'd5, 8'd25);
    period("after_reset_again", 8'd16, 8'd255);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sa2_squarer.md
Name: sa2_squarer

Overview:
- Sequential shift-and-add squarer: repeatedly samples the 8-bit operand `a`, computes a*a over several clocks using one adder, and registers the result on `q`.
- Runs continuously with no start/done handshake. `q` holds the most recent completed result until the next computation finishes.
- Intended as a small arithmetic leaf block, a single-operand companion to a two-operand shift-add multiplier.

Parameters:
- W, 8, operand and result width in bits. The internal accumulator and shifted multiplicand are 2*W bits. The iteration count is W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  W  operand to be squared; sampled only in the LOAD state.
- q  output  W  registered result, saturated square of the last sampled `a`.
- Positional port declaration order is fixed: a, reset, clk, q. Instantiations connect by position.

Behaviour:
- Reset (asynchronous, active-high) while `reset`=1:
  - state=LOAD, q=0, acc=0, mcand=0, mplier=0, cnt=0.
  - Reset held or asserted at any time, including mid-computation, aborts the current computation immediately.
  - The first LOAD occurs on the first rising edge after `reset` deasserts.
- States: LOAD -> ITER -> DONE -> LOAD, free-running.
- LOAD (1 cycle):
  - mcand <= zero-extended `a` (2W bits); mplier <= `a`; acc <= 0; cnt <= 0.
  - Next state is ITER.
- ITER (exactly W cycles):
  - If mplier[0]=1, acc <= acc + mcand; the 2W-bit add cannot overflow.
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - Leave for DONE when cnt = W-1 on that edge.
- DONE (1 cycle):
  - If acc > 2^W-1, q <= all ones (8'hFF); otherwise q <= acc[W-1:0].
  - Next state is LOAD.
- Timing:
  - Full period is W+2 = 10 clocks.
  - `q` updates only on the DONE edge, 9 edges after the LOAD edge that sampled `a`.
  - Changes on `a` outside LOAD are ignored until the next LOAD.
- Unknown operand: if `a` is X/Z when sampled, `q` may go X for that period. It recovers on the next period once `a` is valid.
- Boundaries:
  - a=0 gives q=0.
  - a=15 gives q=225.
  - a=16 gives 256, saturating to q=255.
  - a=255 gives q=255.
  - W iterations with mplier shifting right guarantee completion regardless of the operand's bit pattern.
- `q` is a pure register output with no combinational path from `a`.

Test Plan:
- Reset: assert `reset` for 80 ns with a 120 ns clock period -> q=0, state=LOAD, with no clock edge needed (asynchronous).
- Basic operation: release reset, drive a=12 before the first edge -> q=144 exactly 10 edges after reset release; q stays 144 across later periods while a=12.
- Saturation: a=16 -> q=255; a=255 -> q=255; a=15 -> q=225.
- Zero and one: a=0 -> q=0; a=1 -> q=1.
- Operand change mid-computation: change a from 12 to 3 during ITER -> the current period still yields 144; the next period yields 9.
- Reset mid-operation: assert reset during ITER -> q=0 immediately; after release with a=5 -> q=25 within 10 edges.
